// File: rtl/sample_window_buffer.sv
// Window buffer: fetches a WIN_ROWS x WIN_COLS pixel window over the SI read channel,
// either as a full reload or by sliding the held window left by STEP columns.
module sample_window_buffer #(
    parameter int PIX_W    = 8,
    parameter int BUS_PIX  = 4,
    parameter int WIN_ROWS = 3,
    parameter int WIN_COLS = 4,
    parameter int STEP     = 2,
    parameter int ADDR_W   = 20,
    parameter int DIM_W    = 12
) (
    input  logic                                clk,
    input  logic                                n_rst,
    input  logic [DIM_W-1:0]                    image_width,
    input  logic                                fill_buff,
    input  logic                                slide,
    input  logic [ADDR_W-1:0]                   ED_rpixNum,
    input  logic                                SI_dfb,
    input  logic [BUS_PIX*PIX_W-1:0]            SI_rdata,
    output logic [1:0]                          SI_mode,
    output logic [ADDR_W-1:0]                   SI_rpixNum,
    output logic                                buff_filled,
    output logic                                busy,
    output logic                                win_valid,
    output logic [WIN_ROWS*WIN_COLS*PIX_W-1:0]  ED_rdata
);

    localparam int WPR    = WIN_COLS / BUS_PIX;
    localparam int ROW_W  = (WIN_ROWS > 1) ? $clog2(WIN_ROWS) : 1;
    localparam int WORD_W = (WPR > 1) ? $clog2(WPR) : 1;

    localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(WIN_ROWS - 1);
    localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(WPR - 1);
    localparam logic [ADDR_W-1:0] SLIDE_OFS = ADDR_W'(WIN_COLS - STEP);
    localparam logic [ADDR_W-1:0] BUS_OFS   = ADDR_W'(BUS_PIX);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t              state;
    logic                slide_eff;
    logic [ROW_W-1:0]    row;
    logic [WORD_W-1:0]   word;
    logic [ADDR_W-1:0]   row_base;
    logic [PIX_W-1:0]    shadow     [WIN_ROWS][WIN_COLS];
    logic [PIX_W-1:0]    window     [WIN_ROWS][WIN_COLS];
    logic [PIX_W-1:0]    shadow_nxt [WIN_ROWS][WIN_COLS];
    logic                row_end;
    logic                last_word;
    logic [ADDR_W-1:0]   next_row_base;

    // Shadow image after merging the current SI word into the active row.
    always_comb begin
        row_end       = slide_eff || (word == LAST_WORD);
        last_word     = row_end && (row == LAST_ROW);
        next_row_base = row_base + ADDR_W'(image_width);
        shadow_nxt    = shadow;
        for (int unsigned r = 0; r < WIN_ROWS; r++) begin
            if (ROW_W'(r) == row) begin
                if (slide_eff) begin
                    for (int unsigned c = 0; c < WIN_COLS - STEP; c++)
                        shadow_nxt[r][c] = window[r][c + STEP];
                    for (int unsigned i = 0; i < STEP; i++)
                        shadow_nxt[r][WIN_COLS - STEP + i] = SI_rdata[i*PIX_W +: PIX_W];
                end else begin
                    for (int unsigned w = 0; w < WPR; w++) begin
                        if (WORD_W'(w) == word) begin
                            for (int unsigned i = 0; i < BUS_PIX; i++)
                                shadow_nxt[r][w*BUS_PIX + i] = SI_rdata[i*PIX_W +: PIX_W];
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        ED_rdata = '0;
        for (int unsigned r = 0; r < WIN_ROWS; r++)
            for (int unsigned c = 0; c < WIN_COLS; c++)
                ED_rdata[(r*WIN_COLS + c)*PIX_W +: PIX_W] = window[r][c];
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state       <= IDLE;
            slide_eff   <= 1'b0;
            row         <= '0;
            word        <= '0;
            row_base    <= '0;
            shadow      <= '{default: '0};
            window      <= '{default: '0};
            SI_mode     <= 2'b00;
            SI_rpixNum  <= '0;
            buff_filled <= 1'b0;
            busy        <= 1'b0;
            win_valid   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    buff_filled <= 1'b0;
                    if (fill_buff) begin
                        state      <= REQ;
                        slide_eff  <= slide & win_valid;
                        row        <= '0;
                        word       <= '0;
                        row_base   <= ED_rpixNum;
                        SI_rpixNum <= ED_rpixNum + ((slide & win_valid) ? SLIDE_OFS : '0);
                        SI_mode    <= 2'b01;
                        busy       <= 1'b1;
                    end
                end
                REQ: begin
                    if (SI_dfb) begin
                        shadow <= shadow_nxt;
                        if (last_word) begin
                            // Commit includes the word captured on this same edge.
                            window      <= shadow_nxt;
                            win_valid   <= 1'b1;
                            state       <= DONE;
                            SI_mode     <= 2'b00;
                            busy        <= 1'b0;
                            buff_filled <= 1'b1;
                        end else if (row_end) begin
                            row        <= row + ROW_W'(1);
                            word       <= '0;
                            row_base   <= next_row_base;
                            SI_rpixNum <= next_row_base + (slide_eff ? SLIDE_OFS : '0);
                        end else begin
                            word       <= word + WORD_W'(1);
                            SI_rpixNum <= SI_rpixNum + BUS_OFS;
                        end
                    end
                end
                DONE: begin
                    buff_filled <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sample_window_buffer.sv
// Bench for sample_window_buffer: memory responder plus an array-based window model.
module tb_sample_window_buffer;

    localparam int PIX_W    = 8;
    localparam int BUS_PIX  = 4;
    localparam int WIN_ROWS = 3;
    localparam int WIN_COLS = 4;
    localparam int STEP     = 2;
    localparam int ADDR_W   = 20;
    localparam int DIM_W    = 12;
    localparam int BUS_W    = BUS_PIX * PIX_W;
    localparam int ED_W     = WIN_ROWS * WIN_COLS * PIX_W;
    localparam int unsigned AMASK = (1 << ADDR_W) - 1;

    logic              tb_clk;
    logic              n_rst;
    logic [DIM_W-1:0]  image_width;
    logic              fill_buff;
    logic              slide;
    logic [ADDR_W-1:0] ED_rpixNum;
    logic              SI_dfb;
    logic [BUS_W-1:0]  SI_rdata;
    logic [1:0]        SI_mode;
    logic [ADDR_W-1:0] SI_rpixNum;
    logic              buff_filled;
    logic              busy;
    logic              win_valid;
    logic [ED_W-1:0]   ED_rdata;

    int unsigned checks = 0;
    int unsigned errors = 0;

    int unsigned mem_mode = 0;
    int unsigned mem_seed = 0;
    int unsigned resp_delay = 0;
    bit          idle_pulse = 0;
    int unsigned addr_q[$];

    int unsigned exp_win [WIN_ROWS][WIN_COLS];
    bit          m_valid;

    sample_window_buffer #(
        .PIX_W(PIX_W), .BUS_PIX(BUS_PIX), .WIN_ROWS(WIN_ROWS), .WIN_COLS(WIN_COLS),
        .STEP(STEP), .ADDR_W(ADDR_W), .DIM_W(DIM_W)
    ) dut (
        .clk(tb_clk), .n_rst(n_rst), .image_width(image_width), .fill_buff(fill_buff),
        .slide(slide), .ED_rpixNum(ED_rpixNum), .SI_dfb(SI_dfb), .SI_rdata(SI_rdata),
        .SI_mode(SI_mode), .SI_rpixNum(SI_rpixNum), .buff_filled(buff_filled),
        .busy(busy), .win_valid(win_valid), .ED_rdata(ED_rdata)
    );

    initial begin
        tb_clk = 1'b0;
        forever #5 tb_clk = ~tb_clk;
    end

    function automatic logic [PIX_W-1:0] mem_pix(input int unsigned a);
        if (mem_mode == 0) return PIX_W'(a);
        return PIX_W'((a * 29) ^ mem_seed);
    endfunction

    function automatic logic [BUS_W-1:0] mem_word(input int unsigned a);
        logic [BUS_W-1:0] w;
        w = '0;
        for (int i = 0; i < BUS_PIX; i++) w[i*PIX_W +: PIX_W] = mem_pix((a + i) & AMASK);
        return w;
    endfunction

    function automatic logic [ED_W-1:0] pack_win();
        logic [ED_W-1:0] v;
        v = '0;
        for (int r = 0; r < WIN_ROWS; r++)
            for (int c = 0; c < WIN_COLS; c++)
                v[(r*WIN_COLS + c)*PIX_W +: PIX_W] = PIX_W'(exp_win[r][c]);
        return v;
    endfunction

    // Image memory: answers each pending request after resp_delay idle cycles.
    initial begin
        int unsigned cnt;
        cnt = 0;
        SI_dfb = 1'b0;
        SI_rdata = '0;
        forever begin
            @(negedge tb_clk);
            if (SI_mode == 2'b01) begin
                if (cnt >= resp_delay) begin
                    SI_dfb = 1'b1;
                    SI_rdata = mem_word(SI_rpixNum);
                    addr_q.push_back(SI_rpixNum);
                    cnt = 0;
                end else begin
                    SI_dfb = 1'b0;
                    cnt++;
                end
            end else begin
                cnt = 0;
                SI_dfb = idle_pulse;
                SI_rdata = idle_pulse ? BUS_W'($urandom) : '0;
            end
        end
    end

    task automatic check_idle_outputs(input string tag);
        checks++;
        if ({SI_mode, SI_rpixNum, buff_filled, busy, win_valid, ED_rdata} !== '0) begin
            errors++;
            $display("FAIL %s: outputs mode=%0h addr=%0h bf=%0b busy=%0b wv=%0b ed=%0h, expected all 0",
                     tag, SI_mode, SI_rpixNum, buff_filled, busy, win_valid, ED_rdata);
        end
    endtask

    task automatic apply_reset();
        fill_buff = 0; slide = 0; ED_rpixNum = '0; image_width = '0;
        n_rst = 0;
        for (int r = 0; r < WIN_ROWS; r++)
            for (int c = 0; c < WIN_COLS; c++) exp_win[r][c] = 0;
        m_valid = 0;
        repeat (3) @(posedge tb_clk);
        #1 check_idle_outputs("reset_state");
        @(negedge tb_clk);
        n_rst = 1;
    endtask

    task automatic do_fill(input int unsigned base, input bit sl, input int unsigned width,
                           input int unsigned delay, input bit spam);
        int unsigned new_win [WIN_ROWS][WIN_COLS];
        int unsigned exp_addr[$];
        int unsigned rb, q0, edges, budget, k;
        logic [ED_W-1:0] old_pack;
        bit se, done;
        se = sl && m_valid;
        for (int r = 0; r < WIN_ROWS; r++) begin
            rb = (base + r * width) & AMASK;
            if (se) begin
                exp_addr.push_back((rb + WIN_COLS - STEP) & AMASK);
                for (int c = 0; c < WIN_COLS; c++) begin
                    if (c < WIN_COLS - STEP) new_win[r][c] = exp_win[r][c + STEP];
                    else new_win[r][c] = mem_pix((rb + c) & AMASK);
                end
            end else begin
                for (int w = 0; w < WIN_COLS / BUS_PIX; w++) exp_addr.push_back((rb + w * BUS_PIX) & AMASK);
                for (int c = 0; c < WIN_COLS; c++) new_win[r][c] = mem_pix((rb + c) & AMASK);
            end
        end
        old_pack = pack_win();
        resp_delay = delay;
        q0 = addr_q.size();
        budget = exp_addr.size() * (delay + 1) + 20;

        @(negedge tb_clk);
        image_width = DIM_W'(width); ED_rpixNum = ADDR_W'(base); slide = sl; fill_buff = 1;
        @(posedge tb_clk); #1;
        if (!spam) fill_buff = 0;
        edges = 0; done = 0;
        while (!done && edges <= budget) begin
            if (buff_filled) done = 1;
            else begin
                k = addr_q.size() - q0;
                checks++;
                if (busy !== 1'b1 || SI_mode !== 2'b01 || ED_rdata !== old_pack) begin
                    errors++;
                    $display("FAIL fill_wait: busy=%0b mode=%0h ed=%0h, expected busy=1 mode=1 ed=%0h",
                             busy, SI_mode, ED_rdata, old_pack);
                end
                if (k < exp_addr.size()) begin
                    checks++;
                    if (SI_rpixNum !== ADDR_W'(exp_addr[k])) begin
                        errors++;
                        $display("FAIL req_addr[%0d]: got %0d expected %0d", k, SI_rpixNum, exp_addr[k]);
                    end
                end
                @(posedge tb_clk); #1;
                edges++;
            end
        end
        fill_buff = 0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL fill_timeout: no buff_filled after %0d cycles, expected within %0d", edges, budget);
        end
        checks++;
        if (edges !== exp_addr.size() * (delay + 1)) begin
            errors++;
            $display("FAIL latency: got %0d edges expected %0d", edges, exp_addr.size() * (delay + 1));
        end
        checks++;
        if (addr_q.size() - q0 !== exp_addr.size()) begin
            errors++;
            $display("FAIL word_count: got %0d expected %0d", addr_q.size() - q0, exp_addr.size());
        end
        for (int i = 0; i < exp_addr.size() && q0 + i < addr_q.size(); i++) begin
            checks++;
            if (addr_q[q0 + i] !== exp_addr[i]) begin
                errors++;
                $display("FAIL addr_seq[%0d]: got %0d expected %0d", i, addr_q[q0 + i], exp_addr[i]);
            end
        end
        exp_win = new_win;
        m_valid = 1;
        checks++;
        if (ED_rdata !== pack_win() || win_valid !== 1'b1 || busy !== 1'b0 || SI_mode !== 2'b00) begin
            errors++;
            $display("FAIL commit: ed=%0h wv=%0b busy=%0b mode=%0h, expected ed=%0h wv=1 busy=0 mode=0",
                     ED_rdata, win_valid, busy, SI_mode, pack_win());
        end
        @(posedge tb_clk); #1;
        checks++;
        if (buff_filled !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL pulse_width: bf=%0b busy=%0b after DONE, expected 0 0", buff_filled, busy);
        end
    endtask

    task automatic test_reset();
        apply_reset();
    endtask

    task automatic test_full_fill();
        logic [ED_W-1:0] v;
        mem_mode = 0;
        do_fill(9, 0, 8, 0, 0);
        v = ED_rdata;
        checks++;
        if (v[7:0] !== 8'd9 || v[(2*WIN_COLS + 3)*PIX_W +: PIX_W] !== 8'd28) begin
            errors++;
            $display("FAIL full_corners: got %0d,%0d expected 9,28", v[7:0], v[(2*WIN_COLS + 3)*PIX_W +: PIX_W]);
        end
    endtask

    task automatic test_slide();
        logic [ED_W-1:0] v;
        do_fill(11, 1, 8, 0, 0);
        v = ED_rdata;
        checks++;
        if (v[7:0] !== 8'd11 || v[(2*WIN_COLS + 3)*PIX_W +: PIX_W] !== 8'd30) begin
            errors++;
            $display("FAIL slide_corners: got %0d,%0d expected 11,30", v[7:0], v[(2*WIN_COLS + 3)*PIX_W +: PIX_W]);
        end
    endtask

    task automatic test_stall();
        do_fill(40, 0, 8, 5, 0);
        do_fill(42, 1, 8, 5, 0);
    endtask

    task automatic test_slide_after_reset();
        apply_reset();
        checks++;
        if (win_valid !== 1'b0) begin
            errors++;
            $display("FAIL wv_after_reset: got %0b expected 0", win_valid);
        end
        do_fill(0, 1, 8, 0, 0);
    endtask

    task automatic test_reset_mid_fill();
        resp_delay = 0;
        @(negedge tb_clk);
        image_width = 8; ED_rpixNum = 9; slide = 0; fill_buff = 1;
        @(posedge tb_clk); #1;
        fill_buff = 0;
        repeat (2) @(posedge tb_clk);
        #1 n_rst = 0;
        for (int r = 0; r < WIN_ROWS; r++)
            for (int c = 0; c < WIN_COLS; c++) exp_win[r][c] = 0;
        m_valid = 0;
        #1 check_idle_outputs("mid_fill_reset");
        repeat (3) begin
            @(posedge tb_clk); #1;
            check_idle_outputs("reset_hold");
        end
        @(negedge tb_clk);
        n_rst = 1;
        do_fill(9, 0, 8, 0, 0);
    endtask

    task automatic test_ignored();
        do_fill(100, 0, 8, 2, 1);
        do_fill(102, 1, 8, 1, 1);
        idle_pulse = 1;
        for (int i = 0; i < 6; i++) begin
            if (i == 3) idle_pulse = 0;
            @(posedge tb_clk); #1;
            checks++;
            if (buff_filled !== 1'b0 || busy !== 1'b0 || SI_mode !== 2'b00 || ED_rdata !== pack_win()) begin
                errors++;
                $display("FAIL idle_dfb: bf=%0b busy=%0b mode=%0h ed=%0h, expected 0 0 0 ed=%0h",
                         buff_filled, busy, SI_mode, ED_rdata, pack_win());
            end
        end
    endtask

    task automatic test_random();
        mem_mode = 1;
        mem_seed = $urandom;
        for (int n = 0; n < 12; n++)
            do_fill($urandom & AMASK, 1'($urandom), $urandom_range(8, 300),
                    $urandom_range(0, 3), 1'($urandom));
    endtask

    initial begin
        n_rst = 0; fill_buff = 0; slide = 0; ED_rpixNum = '0; image_width = '0;
        test_reset();
        test_full_fill();
        test_slide();
        test_stall();
        test_slide_after_reset();
        test_reset_mid_fill();
        test_ignored();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
